// File: rtl/pipeline_ctrl_pkg.sv
// Shared rv32i word/register types plus PC-mux and fetch-state enums used by
// the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

  typedef logic [31:0] rv32i_word;
  typedef logic [4:0]  rv32i_reg;

  typedef enum logic {
    PC_PLUS4    = 1'b0,
    PC_REDIRECT = 1'b1
  } pcmux_sel_t;

  typedef enum logic {
    F_RUN  = 1'b0,
    F_PEND = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; cleared by the active-low synchronous reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage rv32i pipeline: load-use, memory wait
// states and EX redirects, including a redirect taken while a fetch is outstanding.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  rv32i_reg         id_rs1,
  input  rv32i_reg         id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  rv32i_reg         ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  rv32i_word        ex_target,
  output logic             load_pc,
  output pcmux_sel_t       pc_sel,
  output rv32i_word        pc_target,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             imem_read,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic         stall_mem;
  logic         load_use;
  fetch_state_t state_q, state_d;
  rv32i_word    tgt_q, tgt_d;
  logic         stall_inc;
  logic         flush_inc;

  assign stall_mem = dmem_req & ~dmem_resp;
  assign load_use  = ex_is_load & (ex_rd != '0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                      (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= F_RUN;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    load_pc     = 1'b1;
    pc_sel      = PC_PLUS4;
    pc_target   = '0;
    load_if_id  = 1'b1;
    load_id_ex  = 1'b1;
    load_ex_mem = 1'b1;
    load_mem_wb = 1'b1;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    imem_read   = 1'b1;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    if (!rst) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      imem_read   = 1'b0;
    end else if (state_q == F_PEND) begin
      // IF/ID keeps its bubble; the word fetched from the stale PC is dropped
      load_if_id  = 1'b0;
      flush_id_ex = 1'b1;
      load_id_ex  = ~stall_mem;
      load_ex_mem = ~stall_mem;
      load_mem_wb = ~stall_mem;
      load_pc     = imem_resp;
      stall_inc   = 1'b1;
      if (imem_resp) begin
        pc_sel    = PC_REDIRECT;
        pc_target = tgt_q;
        state_d   = F_RUN;
      end
    end else begin
      stall_inc = stall_mem | load_use | ~imem_resp;
      if (stall_mem) begin
        // EX is frozen, so a redirect there is simply seen again next cycle
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
      end else if (ex_redirect) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        flush_inc   = 1'b1;
        if (imem_resp) begin
          pc_sel    = PC_REDIRECT;
          pc_target = ex_target;
        end else begin
          load_pc = 1'b0;
          tgt_d   = ex_target;
          state_d = F_PEND;
        end
      end else if (load_use) begin
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        flush_id_ex = 1'b1;
      end else if (!imem_resp) begin
        load_pc     = 1'b0;
        flush_if_id = 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule
